axi_wr_slave_sram: RTL and testbench
====================================

Name: axi_wr_slave_sram

Overview:
- AXI3 write-channel responder (AW/W/B).
- Accepts one write transaction at a time from an AXI initiator such as the sram2axi bridge write path, and commits each data beat to a word-addressed synchronous SRAM write port.
- Returns a B response after the final beat.
- Used as the bench/SoC-side memory target for the CPU's AXI write traffic.

Parameters:
MEM_AW, 16, SRAM word-address width; valid byte range is 0 .. 2^(MEM_AW+2)-1
MAX_LEN, 15, largest accepted awlen (beats = awlen+1)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous, active-low reset
awid  input  4  write transaction ID
awaddr  input  32  start byte address
awlen  input  8  burst length minus 1
awsize  input  3  log2 bytes per beat
awburst  input  2  00 FIXED, 01 INCR, 10 WRAP
awvalid  input  1  AW valid
awready  output  1  AW ready
wid  input  4  write data ID
wdata  input  32  write data
wstrb  input  4  byte strobes
wlast  input  1  last beat marker
wvalid  input  1  W valid
wready  output  1  W ready
bid  output  4  response ID
bresp  output  2  00 OKAY, 10 SLVERR
bvalid  output  1  B valid
bready  input  1  B ready
mem_en  output  1  SRAM write enable, one cycle per beat
mem_wen  output  4  SRAM byte write enables
mem_addr  output  MEM_AW  SRAM word address
mem_wdata  output  32  SRAM write data

Behaviour:
- Reset (resetn low, async): state IDLE; all internal registers zero.
  - Outputs: awready=1, wready=0, bvalid=0, bid=0, bresp=00, mem_en=0, mem_wen=0.
- States: IDLE, WDATA, BRESP.
  - awready = (state==IDLE).
  - wready = (state==WDATA).
  - bvalid = (state==BRESP).
- IDLE:
  - On awvalid&&awready, latch awid, awaddr, awlen, awsize and awburst.
  - Clear the beat counter and the error flag; go to WDATA next cycle.
  - W beats presented in IDLE are not accepted (wready=0).
- Error flag set at AW acceptance when any of these holds: awsize>2, awlen>MAX_LEN, or awburst==10. WRAP is unsupported and is addressed as INCR.
- WDATA, each beat (wvalid&&wready):
  - mem_en=1 in the same cycle (combinational from the handshake).
  - mem_addr = addr_reg[MEM_AW+1:2]; mem_wdata = wdata.
  - mem_wen = wstrb if the beat is in range and the error flag is clear; otherwise 4'b0.
  - Strobes pass through unmodified; the initiator supplies lane-correct strobes for narrow beats.
- Beat in range: addr_reg[31:MEM_AW+2]==0. An out-of-range beat sets the error flag.
- Address update after each beat:
  - INCR: addr_reg += (1<<awsize), 32-bit wrap-around.
  - FIXED: addr_reg unchanged.
- Beat counter increments per beat.
  - Last beat: counter==len_reg.
  - wlast != (counter==len_reg) sets the error flag. No early termination; the block always consumes exactly len_reg+1 beats.
  - On the last beat go to BRESP.
- BRESP:
  - bid = id_reg; bresp = error flag ? 10 : 00.
  - Hold bvalid and bid/bresp stable until bready; on bvalid&&bready go to IDLE.
  - Earliest next AW acceptance is the cycle after the B handshake.
- Latency for a 1-beat write, no stalls: AW accepted cycle 0, W accepted cycle 1 (SRAM written), bvalid cycle 2.
- Simultaneous events:
  - awvalid and wvalid arriving in the same cycle: AW is taken first, W on the following cycle.
  - bready may already be high on bvalid's first cycle; the transfer completes that cycle.
- Reset mid-burst: the transaction is dropped and no B response is issued. Beats already written stay in the SRAM.

Optional Feature:
- Macro WID_CHECK_EN.
- Defined: each W beat compares wid with id_reg. A mismatch sets the error flag and suppresses mem_wen for that beat (mem_wen=0; mem_en still pulses). The beat is still counted.
- Undefined: wid is ignored entirely.

Test Plan:
- Single write: AW(id=3, addr=0x10, len=0, size=2, INCR), W(0xDEADBEEF, strb=F, last=1) -> mem_addr=4, mem_wen=F in cycle 1; bvalid cycle 2 with bid=3, bresp=00.
- INCR burst: addr=0x100, len=3, size=2, data 1..4 -> mem_addr 0x40,0x41,0x42,0x43; single B OKAY after beat 4.
- Narrow/FIXED: addr=0x21, size=0, FIXED, len=1, strb=0010 then 0010 -> mem_addr=8 twice, mem_wen=0010 twice; OKAY.
- Protocol errors:
  - wlast asserted on beat 1 of a len=2 burst -> 3 beats consumed, bresp=10.
  - awsize=3 -> all mem_wen=0, bresp=10.
- Out of range (MEM_AW=16): addr=0x40000 -> mem_wen=0, bresp=10.
- Backpressure and reset:
  - Hold bready=0 for 5 cycles -> bvalid, bid and bresp stable, awready=0 throughout.
  - Assert resetn low in mid-burst -> awready=1, wready=0, bvalid=0 immediately.
  - With WID_CHECK_EN, wid!=awid on one beat -> that beat's mem_wen=0, bresp=10.

Source files
------------

// File: rtl/axi_wr_slave_sram.sv
// AXI3 write responder (AW/W/B) that commits each beat to a word-addressed SRAM port; WID_CHECK_EN adds a wid check.
// Latency: AW taken cycle 0, first beat written cycle 1, bvalid the cycle after the last beat.
// Backpressure: one transaction at a time; awready only when idle, wready only in data phase, B held until bready.
module axi_wr_slave_sram #(
  parameter int MEM_AW  = 16,
  parameter int MAX_LEN = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] BRESP = 2'd2;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_t;

  logic [1:0] state;
  aw_t        aw_q;
  logic [7:0] cnt;
  logic       err;

  logic aw_hs;
  logic w_hs;
  logic aw_err;
  logic in_range;
  logic last_beat;
  logic wid_bad;
  logic beat_err;

  assign awready = (state == IDLE);
  assign wready  = (state == WDATA);
  assign bvalid  = (state == BRESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // WRAP is flagged as an error but still walks the address like INCR.
  assign aw_err = (awsize > 3'd2) || (awlen > MAX_LEN_B) || (awburst == 2'b10);

  assign in_range  = ((aw_q.addr >> (MEM_AW + 2)) == 32'd0);
  assign last_beat = (cnt == aw_q.len);

`ifdef WID_CHECK_EN
  assign wid_bad = (wid != aw_q.id);
`else
  assign wid_bad = 1'b0;
  logic unused_wid;
  assign unused_wid = ^wid;
`endif

  assign beat_err = !in_range || (wlast != last_beat) || wid_bad;

  assign mem_en    = w_hs;
  assign mem_addr  = aw_q.addr[MEM_AW+1:2];
  assign mem_wdata = wdata;
  // Suppression uses the flag as it stood before this beat plus this beat's own address/ID faults.
  assign mem_wen   = (w_hs && in_range && !err && !wid_bad) ? wstrb : 4'h0;

  assign bid   = aw_q.id;
  assign bresp = err ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      aw_q  <= '0;
      cnt   <= 8'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_q  <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
            cnt   <= 8'd0;
            err   <= aw_err;
            state <= WDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            cnt <= cnt + 8'd1;
            if (beat_err) err <= 1'b1;
            if (aw_q.burst != 2'b00) aw_q.addr <= aw_q.addr + (32'd1 << aw_q.size);
            if (last_beat) state <= BRESP;
          end
        end
        BRESP: begin
          if (bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_sram.sv
// Directed plus randomized bench for axi_wr_slave_sram; expected SRAM beats and B responses come from a transaction-level model.
module tb_axi_wr_slave_sram;

  localparam int MEM_AW  = 16;
  localparam int MAX_LEN = 15;

  logic              clk = 1'b0;
  logic              resetn;
  logic [3:0]        awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [3:0]        wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bdata [0:16];
  logic [3:0]  bstrb [0:16];
  bit          blast [0:16];
  logic [3:0]  bwid  [0:16];

  axi_wr_slave_sram #(.MEM_AW(MEM_AW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_beats(input logic [3:0] id, input int len);
    for (int i = 0; i <= len; i++) begin
      bdata[i] = $urandom;
      bstrb[i] = 4'($urandom);
      blast[i] = (i == len);
      bwid[i]  = id;
    end
  endtask

  task automatic drive_beat(input int i);
    wvalid = 1'b1;
    wdata  = bdata[i];
    wstrb  = bstrb[i];
    wlast  = blast[i];
    wid    = bwid[i];
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {awready, wready, bvalid, bid, bresp, mem_en, mem_wen},
        {1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0});
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Model: the transaction errors if its AW is illegal, or once any beat is out of
  // range, carries a misplaced wlast or (with the ID check) a foreign wid.
  // A beat writes its strobes only if no earlier fault was seen and it is itself clean.
  task automatic do_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst, input int bdelay,
                        input bit early_w, input int gap_max, input int abort_at);
    bit          err;
    bit          wb;
    bit          oor;
    logic [31:0] a;
    logic [3:0]  exp_wen;
    err = (size > 3'd2) || (len > MAX_LEN) || (burst == 2'b10);
    a = addr;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
    awvalid = 1'b1;
    if (early_w) drive_beat(0);
    @(negedge clk);
    chk("aw_ready", awready, 1'b1);
    if (early_w) chk("w_held_in_idle", {wready, mem_en}, 2'b00);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (!(early_w && i == 0)) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          chk("gap_no_en", mem_en, 1'b0);
          @(posedge clk);
          #1;
        end
        drive_beat(i);
      end
      if (i == abort_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_mid_burst", {awready, wready, bvalid, mem_en}, 4'b1000);
        wvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
`ifdef WID_CHECK_EN
      wb = (bwid[i] != id);
`else
      wb = 1'b0;
`endif
      oor = (a >= 32'h0004_0000);
      exp_wen = (!oor && !err && !wb) ? bstrb[i] : 4'h0;
      @(negedge clk);
      chk("w_ready", wready, 1'b1);
      chk("mem_en", mem_en, 1'b1);
      chk("mem_addr", mem_addr, a[MEM_AW+1:2]);
      chk("mem_wen", mem_wen, exp_wen);
      chk("mem_wdata", mem_wdata, bdata[i]);
      if (oor || (blast[i] != (i == len)) || wb) err = 1'b1;
      if (burst != 2'b00) a = a + (32'd1 << size);
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    repeat (bdelay) begin
      @(negedge clk);
      chk("b_hold", {bvalid, bid, bresp, awready}, {1'b1, id, (err ? 2'b10 : 2'b00), 1'b0});
      @(posedge clk);
      #1;
    end
    bready = 1'b1;
    @(negedge clk);
    chk("b_resp", {bvalid, bid, bresp}, {1'b1, id, (err ? 2'b10 : 2'b00)});
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    chk("b_done", {bvalid, awready}, 2'b01);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    int          r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;

    do_reset();

    // Single beat, latency 0/1/2
    fill_beats(4'd3, 0);
    bdata[0] = 32'hDEAD_BEEF; bstrb[0] = 4'hF;
    do_txn(4'd3, 32'h10, 0, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // INCR burst of 4
    fill_beats(4'd5, 3);
    for (int i = 0; i < 4; i++) begin bdata[i] = 32'(i + 1); bstrb[i] = 4'hF; end
    do_txn(4'd5, 32'h100, 3, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // Narrow FIXED
    fill_beats(4'd1, 1);
    bstrb[0] = 4'b0010; bstrb[1] = 4'b0010;
    do_txn(4'd1, 32'h21, 1, 3'd0, 2'b00, 1, 1'b0, 0, -1);

    // Early wlast on a 3-beat burst
    fill_beats(4'd7, 2);
    blast[1] = 1'b1; blast[2] = 1'b0;
    do_txn(4'd7, 32'h200, 2, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // Illegal size
    fill_beats(4'd2, 1);
    do_txn(4'd2, 32'h0, 1, 3'd3, 2'b01, 0, 1'b0, 0, -1);

    // Out of range
    fill_beats(4'd4, 0);
    do_txn(4'd4, 32'h0004_0000, 0, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // B backpressure for 5 cycles
    fill_beats(4'd9, 1);
    do_txn(4'd9, 32'h300, 1, 3'd2, 2'b01, 5, 1'b0, 0, -1);

    // AW and W presented together
    fill_beats(4'd6, 1);
    do_txn(4'd6, 32'h400, 1, 3'd2, 2'b01, 0, 1'b1, 0, -1);

    // WRAP is an error, addressed as INCR; len above MAX_LEN is an error
    fill_beats(4'd8, 3);
    do_txn(4'd8, 32'h500, 3, 3'd2, 2'b10, 0, 1'b0, 0, -1);
    fill_beats(4'd10, 16);
    do_txn(4'd10, 32'h600, 16, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // Crossing the top of the SRAM mid-burst
    fill_beats(4'd11, 3);
    do_txn(4'd11, 32'h0003_FFF8, 3, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // wid mismatch on beat 1 (errors only with the ID check built in)
    fill_beats(4'd12, 2);
    bwid[1] = 4'd13;
    do_txn(4'd12, 32'h700, 2, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    // Reset in the middle of a burst, then a clean transaction
    fill_beats(4'd14, 3);
    do_txn(4'd14, 32'h800, 3, 3'd2, 2'b01, 0, 1'b0, 0, 2);
    fill_beats(4'd15, 0);
    do_txn(4'd15, 32'h900, 0, 3'd2, 2'b01, 0, 1'b0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      r_id    = 4'($urandom);
      r_len   = ($urandom_range(0, 9) == 0) ? 16 : int'($urandom_range(0, 7));
      r_size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      r_burst = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0, 1:    r_addr = $urandom & 32'h0003_FFFF;
        2:       r_addr = 32'h0003_FFF0 + 32'($urandom_range(0, 15));
        default: r_addr = 32'hFFFF_FFF8;
      endcase
      fill_beats(r_id, r_len);
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = int'($urandom_range(0, r_len));
        blast[k] = ~blast[k];
      end
      if ($urandom_range(0, 7) == 0) bwid[$urandom_range(0, r_len)] = ~r_id;
      do_txn(r_id, r_addr, r_len, r_size, r_burst, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
